pe_tile_scheduler: RTL and testbench
====================================

Name: pe_tile_scheduler

Overview:
- Sequences one piPEline PE through a complete tile.
- Latches the 13-bit tile config and pulses the PE enable for one cycle.
- Routes three upstream word streams (filter, ifmap, ipsum) to the PE in the exact order and word counts the PE consumes, then forwards opsums downstream.
- Sits between the global-buffer read ports and a PE; raises done once every output column has drained.

Parameters:
- DATA_BITS, 32, width of every data word (4 packed int8 for filter/ifmap, one int32 for psum).
- CONFIG_SIZE, 13, tile config width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin tile; sampled only in IDLE
- cfg  in  CONFIG_SIZE  [12] depthwise, [11:10] rs-1, [9] mode, [8:7] p-1, [6:2] F (columns = F+1), [1:0] q-1
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last opsum handshake
- pe_en  out  1  one-cycle enable to PE
- pe_config  out  CONFIG_SIZE  latched cfg, held stable until next start
- filter_in_valid/ready, filter_in_data  in/out, DATA_BITS  upstream filter stream
- ifmap_in_valid/ready, ifmap_in_data  in/out, DATA_BITS  upstream ifmap stream
- ipsum_in_valid/ready, ipsum_in_data  in/out, DATA_BITS  upstream ipsum stream
- pe_filter_valid/pe_ifmap_valid/pe_ipsum_valid  out  1  to PE
- pe_filter/pe_ifmap/pe_ipsum  out  DATA_BITS  to PE; combinational copy of upstream data
- pe_filter_ready/pe_ifmap_ready/pe_ipsum_ready  in  1  from PE
- pe_opsum  in  DATA_BITS, pe_opsum_valid  in  1, pe_opsum_ready  out  1  PE output
- opsum_out_data  out  DATA_BITS, opsum_out_valid  out  1, opsum_out_ready  in  1  downstream

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE; all counters and the config register clear.
  - All outputs are 0: busy, done, pe_en, every valid/ready, pe_config.
  - Reset mid-tile abandons the tile with no done pulse. The PE is reset separately.
- Derived counts, from latched cfg:
  - RS = rs-1+1, P = p-1+1, Q = q-1+1.
  - NF = P*RS (1..16).
  - NI0 = RS for column 0, 1 for later columns.
  - NP = Q if depthwise, else P.
  - NC = F+1.
- States: IDLE, CFG, FILTER, IFMAP, IPSUM, OPSUM, DONE.
  - IDLE: start=1 latches cfg, sets busy, goes to CFG.
  - CFG: pe_en=1 for exactly this cycle; go to FILTER.
  - FILTER: pass-through. pe_filter_valid = filter_in_valid; filter_in_ready = pe_filter_ready. Count handshakes; the NF-th handshake moves to IFMAP.
  - IFMAP: same pass-through with the ifmap pair. NI0 handshakes in column 0, 1 handshake thereafter, then go to IPSUM.
  - IPSUM: same pass-through with the ipsum pair. NP handshakes, then go to OPSUM.
  - OPSUM: pe_opsum_ready = opsum_out_ready; opsum_out_valid = pe_opsum_valid; data combinational. After NP handshakes: if col == NC-1 go to DONE, else col++ and go to IFMAP.
  - DONE: done=1 and busy=0 in this cycle; go to IDLE.
- Outside its own state, every stream's valid/ready is held 0 and its counter holds 0. No stream is ever granted while another is active.
- A handshake is valid&&ready in the same cycle. A counter increments only on a handshake and clears on every state exit.
- start while busy, or in DONE, is ignored; cfg changes during a tile are ignored.
- A data word is never dropped or duplicated under arbitrary valid/ready stalls on either side.
- Latency: pe_en is asserted 1 cycle after start. The first filter grant is 2 cycles after start. done is asserted 1 cycle after the final opsum handshake.
- Arithmetic: NF is computed as a 5-bit value; all counters are sized to their maximum (filter 5b, ifmap 3b, psum 3b, col 5b), so no wrap is possible.

Decomposition:
- Shared package:
  - cfg field bit-position constants
  - state enum
  - a function computing NF/NP from cfg
- Sub-module stream_gate: one valid/ready pass-through with enable and handshake counter, instantiated three times for filter/ifmap/ipsum.

Test Plan:
- Basic tile: cfg p-1=1, rs-1=2, q-1=3, F=2, dw=0; all streams always valid/ready -> 6 filter words; ifmap words per column 3,1,1; 2 ipsum and 2 opsum per column; 6 opsums total; done pulses exactly once; pe_en high exactly 1 cycle.
- Depthwise: dw=1, q-1=2, p-1=0, rs-1=2, F=1 -> NF=3; 3 ipsum and 3 opsum per column; 6 opsums total.
- Backpressure: random 50% stalls on every upstream valid, on PE readies and on opsum_out_ready -> output data sequence bit-identical to the no-stall run; no cycle with more than one pe_*_valid high.
- Minimal tile: all cfg fields 0 -> 1 filter, 1 ifmap, 1 ipsum, 1 opsum, done.
- Start while busy and reset mid-tile: start pulsed during IPSUM is ignored. rst low during FILTER -> all outputs 0 next edge. After reset release, a fresh start runs the full tile correctly.

Source files
------------

// File: rtl/pe_tile_scheduler_pkg.sv
// Shared definitions for the PE tile scheduler.
//   - bit positions of the fields inside the 13-bit tile config word
//   - FSM state encodings (state_t)
//   - tile_counts(): derives the per-tile word counts from a config word
package pe_tile_scheduler_pkg;

  // Tile config layout:
  //   [12] depthwise, [11:10] rs-1, [9] mode, [8:7] p-1, [6:2] F, [1:0] q-1
  localparam int CFG_DW    = 12;
  localparam int CFG_RS_LO = 10;
  localparam int CFG_MODE  = 9;
  localparam int CFG_P_LO  = 7;
  localparam int CFG_F_LO  = 2;
  localparam int CFG_Q_LO  = 0;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CFG    = 3'd1;
  localparam state_t ST_FILTER = 3'd2;
  localparam state_t ST_IFMAP  = 3'd3;
  localparam state_t ST_IPSUM  = 3'd4;
  localparam state_t ST_OPSUM  = 3'd5;
  localparam state_t ST_DONE   = 3'd6;

  typedef struct packed {
    logic [4:0] nf;        // filter words for the tile (P*RS, 1..16)
    logic [2:0] np;        // ipsum/opsum words per column (Q or P)
    logic [2:0] rs;        // ifmap words in column 0
    logic [4:0] last_col;  // index of the last output column (F)
  } tile_counts_t;

  function automatic tile_counts_t tile_counts(input logic [12:0] cfg);
    tile_counts_t t;
    logic [2:0]   rs;
    logic [2:0]   p;
    logic [2:0]   q;
    rs = {1'b0, cfg[CFG_RS_LO +: 2]} + 3'd1;
    p  = {1'b0, cfg[CFG_P_LO  +: 2]} + 3'd1;
    q  = {1'b0, cfg[CFG_Q_LO  +: 2]} + 3'd1;
    t.nf       = {2'b00, rs} * {2'b00, p};
    t.np       = cfg[CFG_DW] ? q : p;
    t.rs       = rs;
    t.last_col = cfg[CFG_F_LO +: 5];
    return t;
  endfunction

endpackage

// File: rtl/pe_tile_scheduler_stream_gate.sv
// One gated valid/ready pass-through with a handshake counter.
//   clk, rst      : clock, asynchronous active-low reset
//   en            : stream is granted (owning FSM state is active)
//   target        : number of handshakes that completes this burst (>= 1)
//   in_*          : upstream side (valid/data in, ready out)
//   out_*         : downstream side (valid/data out, ready in)
//   last          : the current cycle carries the target-th handshake
// Handshake rule for both sides: a word moves when valid && ready are high
// in the same cycle; valid/ready are forced to 0 while en is low.
module pe_tile_scheduler_stream_gate #(
  parameter int W  = 32,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [CW-1:0] target,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          last
);

  logic [CW-1:0] cnt;
  logic          hs;

  assign out_valid = en & in_valid;
  assign in_ready  = en & out_ready;
  assign out_data  = in_data;
  assign hs        = out_valid & out_ready;
  assign last      = hs && (cnt == target - CW'(1));

  // The counter holds 0 whenever the stream is not granted, and also clears
  // on the final handshake so it is already 0 when the state is left.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!en || last) begin
      cnt <= '0;
    end else if (hs) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pe_tile_scheduler.sv
// Sequences one pipeline PE through a complete tile: latches the tile
// config, pulses pe_en, then grants filter, ifmap, ipsum and opsum streams
// one at a time in the order and word counts the PE consumes.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   start, cfg               : begin a tile with this config (IDLE only)
//   busy, done, pe_en        : tile status, done pulse, PE enable pulse
//   pe_config                : latched config, stable until next start
//   {filter,ifmap,ipsum}_in_*: upstream streams from the global buffer
//   pe_{filter,ifmap,ipsum}* : the same streams presented to the PE
//   pe_opsum*, opsum_out_*   : PE output stream forwarded downstream
//   dbg_state                : current FSM state (debug visibility)
// Every stream uses valid/ready: a word transfers in a cycle where both are
// high; valid/ready of a stream are 0 outside the state that owns it.
module pe_tile_scheduler
  import pe_tile_scheduler_pkg::*;
#(
  parameter int DATA_BITS   = 32,
  parameter int CONFIG_SIZE = 13
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CONFIG_SIZE-1:0] cfg,
  output logic                   busy,
  output logic                   done,
  output logic                   pe_en,
  output logic [CONFIG_SIZE-1:0] pe_config,
  input  logic                   filter_in_valid,
  output logic                   filter_in_ready,
  input  logic [DATA_BITS-1:0]   filter_in_data,
  input  logic                   ifmap_in_valid,
  output logic                   ifmap_in_ready,
  input  logic [DATA_BITS-1:0]   ifmap_in_data,
  input  logic                   ipsum_in_valid,
  output logic                   ipsum_in_ready,
  input  logic [DATA_BITS-1:0]   ipsum_in_data,
  output logic                   pe_filter_valid,
  output logic                   pe_ifmap_valid,
  output logic                   pe_ipsum_valid,
  output logic [DATA_BITS-1:0]   pe_filter,
  output logic [DATA_BITS-1:0]   pe_ifmap,
  output logic [DATA_BITS-1:0]   pe_ipsum,
  input  logic                   pe_filter_ready,
  input  logic                   pe_ifmap_ready,
  input  logic                   pe_ipsum_ready,
  input  logic [DATA_BITS-1:0]   pe_opsum,
  input  logic                   pe_opsum_valid,
  output logic                   pe_opsum_ready,
  output logic [DATA_BITS-1:0]   opsum_out_data,
  output logic                   opsum_out_valid,
  input  logic                   opsum_out_ready,
  output logic [2:0]             dbg_state
);

  state_t                 state_q;
  state_t                 state_d;
  logic [CONFIG_SIZE-1:0] cfg_q;
  logic [4:0]             col_q;
  logic [2:0]             op_cnt;
  tile_counts_t           counts;
  logic [2:0]             ni;
  logic                   f_last;
  logic                   i_last;
  logic                   p_last;
  logic                   op_hs;
  logic                   op_last;
  logic                   last_col;

  assign counts   = tile_counts(cfg_q[12:0]);
  // Column 0 needs the full RS ifmap window; later columns slide by one.
  assign ni       = (col_q == 5'd0) ? counts.rs : 3'd1;
  assign last_col = (col_q == counts.last_col);

  pe_tile_scheduler_stream_gate #(.W(DATA_BITS), .CW(5)) u_filter (
    .clk(clk), .rst(rst), .en(state_q == ST_FILTER), .target(counts.nf),
    .in_valid(filter_in_valid), .in_ready(filter_in_ready), .in_data(filter_in_data),
    .out_valid(pe_filter_valid), .out_ready(pe_filter_ready), .out_data(pe_filter),
    .last(f_last)
  );

  pe_tile_scheduler_stream_gate #(.W(DATA_BITS), .CW(3)) u_ifmap (
    .clk(clk), .rst(rst), .en(state_q == ST_IFMAP), .target(ni),
    .in_valid(ifmap_in_valid), .in_ready(ifmap_in_ready), .in_data(ifmap_in_data),
    .out_valid(pe_ifmap_valid), .out_ready(pe_ifmap_ready), .out_data(pe_ifmap),
    .last(i_last)
  );

  pe_tile_scheduler_stream_gate #(.W(DATA_BITS), .CW(3)) u_ipsum (
    .clk(clk), .rst(rst), .en(state_q == ST_IPSUM), .target(counts.np),
    .in_valid(ipsum_in_valid), .in_ready(ipsum_in_ready), .in_data(ipsum_in_data),
    .out_valid(pe_ipsum_valid), .out_ready(pe_ipsum_ready), .out_data(pe_ipsum),
    .last(p_last)
  );

  // Opsum path runs in the opposite direction (PE -> downstream).
  assign pe_opsum_ready  = (state_q == ST_OPSUM) & opsum_out_ready;
  assign opsum_out_valid = (state_q == ST_OPSUM) & pe_opsum_valid;
  assign opsum_out_data  = pe_opsum;
  assign op_hs           = opsum_out_valid & opsum_out_ready;
  assign op_last         = op_hs && (op_cnt == counts.np - 3'd1);

  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign pe_en     = (state_q == ST_CFG);
  assign pe_config = cfg_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_CFG;
      ST_CFG:    state_d = ST_FILTER;
      ST_FILTER: if (f_last) state_d = ST_IFMAP;
      ST_IFMAP:  if (i_last) state_d = ST_IPSUM;
      ST_IPSUM:  if (p_last) state_d = ST_OPSUM;
      ST_OPSUM:  if (op_last) state_d = last_col ? ST_DONE : ST_IFMAP;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
      col_q   <= '0;
      op_cnt  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        cfg_q <= cfg;
      end
      if (state_q == ST_IDLE) begin
        col_q <= '0;
      end else if (op_last && !last_col) begin
        col_q <= col_q + 5'd1;
      end
      if (state_q != ST_OPSUM || op_last) begin
        op_cnt <= '0;
      end else if (op_hs) begin
        op_cnt <= op_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_pe_tile_scheduler.sv
// Bench for pe_tile_scheduler. The bench plays the global buffer (three
// numbered word sources), the PE (readies and a numbered opsum source) and
// the downstream sink. Expected {stream, word} pairs are queued per tile
// from hand-computed counts; a monitor pops them in grant order.
module tb_pe_tile_scheduler;

  localparam int DW = 32;
  localparam int CS = 13;

  localparam logic [31:0] BASE_F = 32'h1000_0000;
  localparam logic [31:0] BASE_I = 32'h2000_0000;
  localparam logic [31:0] BASE_P = 32'h3000_0000;
  localparam logic [31:0] BASE_O = 32'hC000_0000;

  // Hand-encoded tile configs
  localparam logic [12:0] CFG_BASIC = 13'h088B; // dw0 rs-1=2 p-1=1 F=2 q-1=3
  localparam logic [12:0] CFG_DWISE = 13'h1806; // dw1 rs-1=2 p-1=0 F=1 q-1=2
  localparam logic [12:0] CFG_MIN   = 13'h0000;
  localparam logic [12:0] CFG_BIG   = 13'h0F80; // rs-1=3 mode=1 p-1=3 F=0

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CS-1:0] cfg;
  logic          busy, done, pe_en;
  logic [CS-1:0] pe_config;
  logic          filter_in_valid, filter_in_ready;
  logic [DW-1:0] filter_in_data;
  logic          ifmap_in_valid, ifmap_in_ready;
  logic [DW-1:0] ifmap_in_data;
  logic          ipsum_in_valid, ipsum_in_ready;
  logic [DW-1:0] ipsum_in_data;
  logic          pe_filter_valid, pe_ifmap_valid, pe_ipsum_valid;
  logic [DW-1:0] pe_filter, pe_ifmap, pe_ipsum;
  logic          pe_filter_ready, pe_ifmap_ready, pe_ipsum_ready;
  logic [DW-1:0] pe_opsum;
  logic          pe_opsum_valid, pe_opsum_ready;
  logic [DW-1:0] opsum_out_data;
  logic          opsum_out_valid, opsum_out_ready;
  logic [2:0]    dbg_state;

  pe_tile_scheduler #(.DATA_BITS(DW), .CONFIG_SIZE(CS)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg(cfg),
    .busy(busy), .done(done), .pe_en(pe_en), .pe_config(pe_config),
    .filter_in_valid(filter_in_valid), .filter_in_ready(filter_in_ready),
    .filter_in_data(filter_in_data),
    .ifmap_in_valid(ifmap_in_valid), .ifmap_in_ready(ifmap_in_ready),
    .ifmap_in_data(ifmap_in_data),
    .ipsum_in_valid(ipsum_in_valid), .ipsum_in_ready(ipsum_in_ready),
    .ipsum_in_data(ipsum_in_data),
    .pe_filter_valid(pe_filter_valid), .pe_ifmap_valid(pe_ifmap_valid),
    .pe_ipsum_valid(pe_ipsum_valid),
    .pe_filter(pe_filter), .pe_ifmap(pe_ifmap), .pe_ipsum(pe_ipsum),
    .pe_filter_ready(pe_filter_ready), .pe_ifmap_ready(pe_ifmap_ready),
    .pe_ipsum_ready(pe_ipsum_ready),
    .pe_opsum(pe_opsum), .pe_opsum_valid(pe_opsum_valid),
    .pe_opsum_ready(pe_opsum_ready),
    .opsum_out_data(opsum_out_data), .opsum_out_valid(opsum_out_valid),
    .opsum_out_ready(opsum_out_ready),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [33:0] exp_q[$];   // {stream tag, word}; tags 0 filter 1 ifmap 2 ipsum 3 opsum
  int n_checks = 0;
  int n_fail   = 0;

  int en_cnt, done_cnt, opsum_seen;
  int en_cyc, done_cyc, last_op_cyc, first_f_cyc, t0;

  bit          stall_en = 1'b0;
  logic [31:0] src_f = 0, src_i = 0, src_p = 0, src_o = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- environment driver ----------------
  // Sources advance their word number only after a handshake, so data is
  // held while stalled; valid/ready toggle randomly when stall_en is set.
  initial begin
    bit hf, hi, hp, ho;
    filter_in_valid = 0; ifmap_in_valid = 0; ipsum_in_valid = 0;
    pe_filter_ready = 0; pe_ifmap_ready = 0; pe_ipsum_ready = 0;
    pe_opsum_valid  = 0; opsum_out_ready = 0;
    filter_in_data = BASE_F; ifmap_in_data = BASE_I;
    ipsum_in_data  = BASE_P; pe_opsum = BASE_O;
    forever begin
      @(negedge clk);
      hf = filter_in_valid && filter_in_ready;
      hi = ifmap_in_valid && ifmap_in_ready;
      hp = ipsum_in_valid && ipsum_in_ready;
      ho = pe_opsum_valid && pe_opsum_ready;
      @(posedge clk);
      #1;
      if (hf) src_f = src_f + 1;
      if (hi) src_i = src_i + 1;
      if (hp) src_p = src_p + 1;
      if (ho) src_o = src_o + 1;
      filter_in_data = BASE_F + src_f;
      ifmap_in_data  = BASE_I + src_i;
      ipsum_in_data  = BASE_P + src_p;
      pe_opsum       = BASE_O + src_o;
      if (stall_en) begin
        filter_in_valid = 1'($urandom_range(0, 1));
        ifmap_in_valid  = 1'($urandom_range(0, 1));
        ipsum_in_valid  = 1'($urandom_range(0, 1));
        pe_filter_ready = 1'($urandom_range(0, 1));
        pe_ifmap_ready  = 1'($urandom_range(0, 1));
        pe_ipsum_ready  = 1'($urandom_range(0, 1));
        pe_opsum_valid  = 1'($urandom_range(0, 1));
        opsum_out_ready = 1'($urandom_range(0, 1));
      end else begin
        filter_in_valid = 1; ifmap_in_valid = 1; ipsum_in_valid = 1;
        pe_filter_ready = 1; pe_ifmap_ready = 1; pe_ipsum_ready = 1;
        pe_opsum_valid  = 1; opsum_out_ready = 1;
      end
    end
  end

  // ---------------- monitor ----------------
  task automatic pop_cmp(input string name, input logic [1:0] tag, input logic [31:0] data);
    logic [33:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_unexpected"}, {tag, data}, 0);
    end else begin
      e = exp_q.pop_front();
      check(name, {tag, data}, e);
    end
  endtask

  initial begin
    int nv;
    forever begin
      @(negedge clk);
      if (rst) begin
        nv = int'(pe_filter_valid) + int'(pe_ifmap_valid) + int'(pe_ipsum_valid)
           + int'(opsum_out_valid);
        if (nv > 0) check("one_stream_valid", nv, 1);
        if (pe_en) begin
          en_cnt++;
          en_cyc = cyc;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          check("busy_low_at_done", busy, 0);
        end
        if (pe_filter_valid && pe_filter_ready) begin
          if (first_f_cyc < 0) first_f_cyc = cyc;
          pop_cmp("filter_word", 2'd0, pe_filter);
        end
        if (pe_ifmap_valid && pe_ifmap_ready) pop_cmp("ifmap_word", 2'd1, pe_ifmap);
        if (pe_ipsum_valid && pe_ipsum_ready) pop_cmp("ipsum_word", 2'd2, pe_ipsum);
        if (opsum_out_valid && opsum_out_ready) begin
          opsum_seen++;
          last_op_cyc = cyc;
          pop_cmp("opsum_word", 2'd3, opsum_out_data);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_expected(input int nf, input int ni0, input int np, input int nc);
    int ii = 0;
    int pi = 0;
    int oi = 0;
    for (int k = 0; k < nf; k++) exp_q.push_back({2'd0, BASE_F + src_f + 32'(k)});
    for (int c = 0; c < nc; c++) begin
      for (int k = 0; k < ((c == 0) ? ni0 : 1); k++) begin
        exp_q.push_back({2'd1, BASE_I + src_i + 32'(ii)});
        ii++;
      end
      for (int k = 0; k < np; k++) begin
        exp_q.push_back({2'd2, BASE_P + src_p + 32'(pi)});
        pi++;
      end
      for (int k = 0; k < np; k++) begin
        exp_q.push_back({2'd3, BASE_O + src_o + 32'(oi)});
        oi++;
      end
    end
  endtask

  task automatic start_tile(input logic [12:0] c, input bit stall);
    en_cnt = 0; done_cnt = 0; opsum_seen = 0;
    en_cyc = -1; done_cyc = -1; last_op_cyc = -100; first_f_cyc = -1;
    stall_en = stall;
    @(posedge clk);
    #1;
    cfg   = c;
    start = 1;
    t0    = cyc;
    @(posedge clk);
    #1;
    start = 0;
    cfg   = ~c;   // changes after the start edge must not leak into the tile
  endtask

  task automatic finish_tile(input logic [12:0] c, input int tot, input bit stall);
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      if (done_cnt != 0) break;
    end
    if (done_cnt == 0) check("done_timeout", 0, 1);
    repeat (4) @(posedge clk);
    check("done_pulses", done_cnt, 1);
    check("pe_en_cycles", en_cnt, 1);
    check("pe_en_latency", en_cyc - t0, 1);
    if (!stall) check("filter_latency", first_f_cyc - t0, 2);
    check("done_latency", done_cyc - last_op_cyc, 1);
    check("opsum_count", opsum_seen, tot);
    check("queue_drained", exp_q.size(), 0);
    check("config_held", pe_config, c);
    check("idle_not_busy", busy, 0);
    exp_q.delete();
  endtask

  task automatic run_tile(input logic [12:0] c, input int nf, input int ni0, input int np,
                          input int nc, input int tot, input bit stall);
    push_expected(nf, ni0, np, nc);
    start_tile(c, stall);
    finish_tile(c, tot, stall);
  endtask

  function automatic longint outs_vec();
    return {busy, done, pe_en, filter_in_ready, ifmap_in_ready, ipsum_in_ready,
            pe_filter_valid, pe_ifmap_valid, pe_ipsum_valid, pe_opsum_ready,
            opsum_out_valid, pe_config, dbg_state};
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    bit seen;
    rst = 0; start = 0; cfg = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", outs_vec(), 0);
    @(posedge clk);
    #1 rst = 1;
    repeat (2) @(posedge clk);

    // Basic tile: NF=6, ifmap 3/1/1, 2 ipsum + 2 opsum per column, 3 columns
    run_tile(CFG_BASIC, 6, 3, 2, 3, 6, 1'b0);
    // Depthwise: NF=3, ifmap 3/1, 3 ipsum + 3 opsum per column, 2 columns
    run_tile(CFG_DWISE, 3, 3, 3, 2, 6, 1'b0);
    // Minimal tile: one word of each
    run_tile(CFG_MIN, 1, 1, 1, 1, 1, 1'b0);
    // Largest filter burst: NF=16, RS=4, P=4, one column
    run_tile(CFG_BIG, 16, 4, 4, 1, 4, 1'b0);
    // Backpressure on every side
    run_tile(CFG_BASIC, 6, 3, 2, 3, 6, 1'b1);
    run_tile(CFG_DWISE, 3, 3, 3, 2, 6, 1'b1);

    // Start pulsed during IPSUM must be ignored
    push_expected(6, 3, 2, 3);
    start_tile(CFG_BASIC, 1'b0);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pe_ipsum_valid) begin
        seen = 1;
        break;
      end
    end
    check("ipsum_reached", seen, 1);
    @(posedge clk);
    #1 start = 1; cfg = 13'h1FFF;
    @(posedge clk);
    #1 start = 0;
    finish_tile(CFG_BASIC, 6, 1'b0);
    repeat (5) @(posedge clk);
    check("no_restart_en", en_cnt, 1);

    // Reset during FILTER abandons the tile
    push_expected(6, 3, 2, 3);
    start_tile(CFG_BASIC, 1'b0);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pe_filter_valid) begin
        seen = 1;
        break;
      end
    end
    check("filter_reached", seen, 1);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("midtile_reset_outputs", outs_vec(), 0);
    exp_q.delete();
    done_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    repeat (5) @(posedge clk);
    check("no_done_after_abort", done_cnt, 0);
    check("idle_after_abort", dbg_state, 0);

    // Fresh tile after reset
    run_tile(CFG_BASIC, 6, 3, 2, 3, 6, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
